// File: rtl/dpd_weight_stream_loader_pkg.sv
// Shared constants, layer dimension tables and enums for the DPD weight stream loader.
package dpd_loader_pack;

  localparam int unsigned W          = 14;
  localparam int unsigned NUM_LAYERS = 4;
  localparam int unsigned MAX_IN     = 48;
  localparam int unsigned MAX_OUT    = 12;
  localparam int unsigned DENSE      = 2;

  localparam int unsigned LAYER_W = $clog2(NUM_LAYERS);
  localparam int unsigned ROW_W   = $clog2(MAX_OUT);
  localparam int unsigned COL_W   = $clog2(MAX_IN);

  // Output layer consumes the concatenated backbone features when DENSE == 2.
  localparam int unsigned LAYER_IN_DIM  [NUM_LAYERS] = '{14, 12, 12, (DENSE == 2) ? 48 : 12};
  localparam int unsigned LAYER_OUT_DIM [NUM_LAYERS] = '{12, 12, 12, 2};

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_LAYER    = 2'd1,
    ERR_LENGTH   = 2'd2,
    ERR_CHECKSUM = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DRAIN
  } state_t;

  function automatic logic [COL_W-1:0] col_last(input logic [LAYER_W-1:0] layer);
    return COL_W'(LAYER_IN_DIM[layer] - 1);
  endfunction

  function automatic logic [ROW_W-1:0] row_last(input logic [LAYER_W-1:0] layer);
    return ROW_W'(LAYER_OUT_DIM[layer] - 1);
  endfunction

endpackage

// File: rtl/dpd_weight_stream_loader_addr_gen.sv
// Row/column/bias address counters for one layer frame; flags the final bias beat.
module dpd_loader_addr_gen
  import dpd_loader_pack::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               adv_i,
  input  logic [LAYER_W-1:0] layer_i,
  output logic [ROW_W-1:0]   row_o,
  output logic [COL_W-1:0]   col_o,
  output logic               bias_o,
  output logic               done_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             bias_q, bias_d;
  logic             row_wrap, col_wrap;

  assign row_wrap = (row_q == row_last(layer_i));
  assign col_wrap = (col_q == col_last(layer_i));

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    bias_d = bias_q;
    if (clear_i) begin
      row_d  = '0;
      col_d  = '0;
      bias_d = 1'b0;
    end else if (adv_i) begin
      if (bias_q) begin
        row_d = row_wrap ? '0 : row_q + 1'b1;
      end else if (col_wrap) begin
        col_d = '0;
        if (row_wrap) begin
          row_d  = '0;
          bias_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      bias_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      bias_q <= bias_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign bias_o = bias_q;
  assign done_o = bias_q && row_wrap;

endmodule

// File: rtl/dpd_weight_stream_loader.sv
// Framed weight/bias stream decoder: writes shadow banks, validates checksum, commits a layer.
module dpd_weight_stream_loader
  import dpd_loader_pack::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [W-1:0]       s_data,
  input  logic               s_last,
  output logic               wr_en,
  output logic [LAYER_W-1:0] wr_layer,
  output logic               wr_bias,
  output logic [ROW_W-1:0]   wr_row,
  output logic [COL_W-1:0]   wr_col,
  output logic [W-1:0]       wr_data,
  output logic               commit,
  output logic [LAYER_W-1:0] commit_layer,
  output logic               err,
  output logic [1:0]         err_code,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               ready_q;
  logic               wr_en_q, wr_en_d;
  logic [LAYER_W-1:0] wr_layer_q;
  logic               wr_bias_q;
  logic [ROW_W-1:0]   wr_row_q;
  logic [COL_W-1:0]   wr_col_q;
  logic [W-1:0]       wr_data_q;
  logic               commit_q, commit_d;
  logic [LAYER_W-1:0] commit_layer_q;
  logic               err_q, err_d;
  err_code_t          err_code_q, err_code_d;

  logic               accept;
  logic               ag_clear, ag_adv, ag_bias, ag_done;
  logic [ROW_W-1:0]   ag_row;
  logic [COL_W-1:0]   ag_col;

  dpd_loader_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (ag_clear),
    .adv_i   (ag_adv),
    .layer_i (layer_q),
    .row_o   (ag_row),
    .col_o   (ag_col),
    .bias_o  (ag_bias),
    .done_o  (ag_done)
  );

  // One-beat bubble while a commit/err pulse is on the output.
  assign s_ready = ready_q && !commit_q && !err_q;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    layer_d    = layer_q;
    wr_en_d    = 1'b0;
    commit_d   = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;
    ag_clear   = 1'b0;
    ag_adv     = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        if (32'(s_data[3:0]) >= NUM_LAYERS) begin
          err_d      = 1'b1;
          err_code_d = ERR_LAYER;
          state_d    = s_last ? IDLE : DRAIN;
        end else if (s_last) begin
          err_d      = 1'b1;
          err_code_d = ERR_LENGTH;
        end else begin
          state_d  = LOAD;
          layer_d  = LAYER_W'(s_data[3:0]);
          sum_d    = '0;
          ag_clear = 1'b1;
        end
      end
      LOAD: if (accept) begin
        if (s_last) begin
          err_d      = 1'b1;
          err_code_d = ERR_LENGTH;
          state_d    = IDLE;
        end else begin
          wr_en_d = 1'b1;
          ag_adv  = 1'b1;
          sum_d   = sum_q + s_data;
          if (ag_done) state_d = CHECK;
        end
      end
      CHECK: if (accept) begin
        if (!s_last) begin
          err_d      = 1'b1;
          err_code_d = ERR_LENGTH;
          state_d    = DRAIN;
        end else if (s_data != sum_q) begin
          err_d      = 1'b1;
          err_code_d = ERR_CHECKSUM;
          state_d    = IDLE;
        end else begin
          commit_d = 1'b1;
          state_d  = IDLE;
        end
      end
      DRAIN: if (accept && s_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sum_q          <= '0;
      layer_q        <= '0;
      ready_q        <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_layer_q     <= '0;
      wr_bias_q      <= 1'b0;
      wr_row_q       <= '0;
      wr_col_q       <= '0;
      wr_data_q      <= '0;
      commit_q       <= 1'b0;
      commit_layer_q <= '0;
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      layer_q    <= layer_d;
      ready_q    <= 1'b1;
      wr_en_q    <= wr_en_d;
      commit_q   <= commit_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      if (wr_en_d) begin
        wr_layer_q <= layer_q;
        wr_bias_q  <= ag_bias;
        wr_row_q   <= ag_row;
        wr_col_q   <= ag_col;
        wr_data_q  <= s_data;
      end
      if (commit_d) commit_layer_q <= layer_q;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_layer     = wr_layer_q;
  assign wr_bias      = wr_bias_q;
  assign wr_row       = wr_row_q;
  assign wr_col       = wr_col_q;
  assign wr_data      = wr_data_q;
  assign commit       = commit_q;
  assign commit_layer = commit_layer_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dpd_weight_stream_loader.sv
// Scoreboard bench for the DPD weight stream loader: directed frames, queued expectations.
module tb_dpd_weight_stream_loader;

  localparam int unsigned DW = 14;
  localparam int unsigned TIN  [4] = '{14, 12, 12, 48};
  localparam int unsigned TOUT [4] = '{12, 12, 12, 2};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          wr_en;
  logic [1:0]    wr_layer;
  logic          wr_bias;
  logic [3:0]    wr_row;
  logic [5:0]    wr_col;
  logic [DW-1:0] wr_data;
  logic          commit;
  logic [1:0]    commit_layer;
  logic          err;
  logic [1:0]    err_code;
  logic          busy;

  dpd_weight_stream_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .wr_en        (wr_en),
    .wr_layer     (wr_layer),
    .wr_bias      (wr_bias),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .commit       (commit),
    .commit_layer (commit_layer),
    .err          (err),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_wr_q [$];
  logic [4:0]  exp_ev_q [$];   // {is_commit, 2'b0, layer} or {0, 2'b0, err_code}
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned wr_seen = 0;
  int unsigned ev_seen = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] pdata(input int unsigned layer, input int unsigned k);
    return DW'(k * 1237 + layer * 611 + 3);
  endfunction

  function automatic void push_wr(input int unsigned layer, input int unsigned k, input logic [DW-1:0] d);
    int unsigned nw = TIN[layer] * TOUT[layer];
    logic        b  = (k >= nw);
    int unsigned r  = b ? k - nw : k / TIN[layer];
    int unsigned c  = b ? 0 : k % TIN[layer];
    exp_wr_q.push_back({5'b0, 2'(layer), b, 4'(r), 6'(c), d});
  endfunction

  // Monitor: every write/commit/err the DUT presents is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_seen++;
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'(exp_wr_q.size()), 32'd1);
        else chk("wr_beat", {5'b0, wr_layer, wr_bias, wr_row, wr_col, wr_data}, exp_wr_q.pop_front());
      end
      if (commit || err) begin
        ev_seen++;
        chk("pulse_exclusive", 32'(commit && err), 32'd0);
        chk("ready_bubble", 32'(s_ready), 32'd0);
        if (exp_ev_q.size() == 0) chk("event_unexpected", 32'(exp_ev_q.size()), 32'd1);
        else chk("event", commit ? {27'b0, 1'b1, 2'b0, commit_layer} : {27'b0, 1'b0, 2'b0, err_code},
                 32'(exp_ev_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic beat(input logic [DW-1:0] d, input logic l, input bit gap);
    int unsigned g = 0;
    if (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready) begin
      @(negedge clk);
      g++;
      if (g > 50) begin
        total++;
        bad++;
        $display("FAIL ready_timeout actual=0 expected=1");
        $fatal(1, "s_ready stuck low");
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic frame(input int unsigned layer, input int delta, input bit gap);
    int unsigned   n   = TIN[layer] * TOUT[layer] + TOUT[layer];
    logic [DW-1:0] sum = '0;
    logic [DW-1:0] d;
    beat(DW'(layer), 1'b0, gap);
    for (int unsigned k = 0; k < n; k++) begin
      d = pdata(layer, k);
      sum = sum + d;
      push_wr(layer, k, d);
      beat(d, 1'b0, gap);
    end
    if (delta == 0) exp_ev_q.push_back({1'b1, 4'(layer)});
    else            exp_ev_q.push_back({1'b0, 4'd3});
    beat(sum + DW'(delta), 1'b1, gap);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  int unsigned w0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", {30'b0, commit, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(s_ready), 1);

    // Layer 0 good frame: 168 weights + 12 biases, column wraps at 13.
    w0 = wr_seen;
    frame(0, 0, 1'b0);
    settle();
    chk("l0_wr_count", wr_seen - w0, 180);
    chk("l0_idle", 32'(busy), 0);

    // Layer 3 frame with checksum off by one.
    w0 = wr_seen;
    frame(3, 1, 1'b0);
    settle();
    chk("l3_wr_count", wr_seen - w0, 98);

    // Bad layer header, drained payload, then a good layer 1 frame.
    w0 = wr_seen;
    exp_ev_q.push_back({1'b0, 4'd1});
    beat(14'h0005, 1'b0, 1'b0);
    chk("drain_busy", 32'(busy), 1);
    for (int unsigned k = 0; k < 10; k++) beat(pdata(3, k), 1'b0, 1'b0);
    beat(14'h0123, 1'b1, 1'b0);
    settle();
    chk("drain_wr_count", wr_seen - w0, 0);
    chk("drain_idle", 32'(busy), 0);
    w0 = wr_seen;
    frame(1, 0, 1'b0);
    settle();
    chk("l1_wr_count", wr_seen - w0, 156);

    // Early s_last on the 50th payload beat of layer 1.
    w0 = wr_seen;
    beat(14'd1, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 49; k++) begin
      push_wr(1, k, pdata(1, k));
      beat(pdata(1, k), 1'b0, 1'b0);
    end
    exp_ev_q.push_back({1'b0, 4'd2});
    beat(pdata(1, 49), 1'b1, 1'b0);
    settle();
    chk("short_wr_count", wr_seen - w0, 49);
    chk("short_idle", 32'(busy), 0);

    // Layer 2 with s_valid toggling every cycle.
    w0 = wr_seen;
    frame(2, 0, 1'b1);
    settle();
    chk("l2_wr_count", wr_seen - w0, 156);

    // Reset during beat 60 of a layer 1 frame, then a fresh frame.
    beat(14'd1, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 58; k++) begin
      push_wr(1, k, pdata(1, k));
      beat(pdata(1, k), 1'b0, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {wr_en, commit, err, err_code, busy, s_ready}, 0);
    chk("midrst_wr_data", 32'(wr_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = wr_seen;
    frame(1, 0, 1'b0);
    settle();
    chk("post_rst_wr_count", wr_seen - w0, 156);

    chk("wr_queue_drained", 32'(exp_wr_q.size()), 0);
    chk("event_queue_drained", 32'(exp_ev_q.size()), 0);
    chk("event_count", ev_seen, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
